// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Multicycle instruction fetch stage. Owns the PC, issues at most one
// outstanding instruction-memory request at a time and presents each fetched
// word downstream on a valid/ready handshake. A taken branch or jump from
// execute (pc_src/pc_target) redirects the PC and squashes any wrong-path
// fetch, including a request that has already been accepted by memory.
//
// Ports
//   clk             rising-edge clock for all state
//   reset           synchronous, active-high reset (dominant over all inputs)
//   pc_src          redirect request, sampled every cycle
//   pc_target       redirect address (low two bits ignored)
//   imem_req_valid  fetch request valid
//   imem_req_ready  memory accepts the request this cycle
//   imem_req_addr   word-aligned fetch address
//   imem_rsp_valid  response valid (one per accepted request, never same cycle)
//   imem_rsp_data   fetched instruction word
//   instr_valid     instruction available downstream
//   instr_ready     downstream consumes the instruction this cycle
//   instr           fetched instruction
//   instr_pc        address of instr
//   instr_pc_plus4  instr_pc + 4 (wraps modulo 2^XLEN)
//
// Flow without redirects: REQ -> WAIT -> HOLD -> REQ, one instruction per
// three cycles at best. DRAIN swallows the response of a request that became
// wrong-path after it was accepted.
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = '0,
  parameter logic [XLEN-1:0] NOP_INSTR = 'h13
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] instr_pc,
  output logic [XLEN-1:0] instr_pc_plus4
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,  // presenting a request for pc
    S_WAIT  = 2'd1,  // request accepted, response outstanding
    S_HOLD  = 2'd2,  // instruction held for downstream
    S_DRAIN = 2'd3   // wrong-path response outstanding, to be discarded
  } state_e;

  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] instr_pc_q, instr_pc_d;

  logic [XLEN-1:0] redirect_pc;

  // Targets are forced onto a word boundary; the low bits of a jump target
  // carry no meaning for a 32-bit-instruction fetch.
  assign redirect_pc = {pc_target[XLEN-1:2], 2'b00};

  // ---------------------------------------------------------------------------
  // Next-state and datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every signal written in this block gets a default first, so no
    // path through the case statements can leave one unassigned and infer a
    // latch.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;

    case (state_q)
      S_REQ: begin
        if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rsp_valid) begin
          state_d    = S_HOLD;
          instr_d    = imem_rsp_data;
          instr_pc_d = pc_q;
        end
      end
      S_HOLD: begin
        if (instr_ready) begin
          pc_d    = pc_q + PC_STEP;
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rsp_valid) begin
          state_d = S_REQ;
        end
      end
      default: begin
        state_d = S_REQ;
      end
    endcase

    // A redirect overrides everything decided above. The only question left
    // is whether a memory transaction is still in flight: if so, its response
    // must be drained before the new target may be requested.
    if (pc_src) begin
      pc_d       = redirect_pc;
      instr_d    = NOP_INSTR;
      instr_pc_d = instr_pc_q;
      case (state_q)
        S_REQ:   state_d = imem_req_ready ? S_DRAIN : S_REQ;
        S_WAIT:  state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        S_HOLD:  state_d = S_REQ;
        S_DRAIN: state_d = imem_rsp_valid ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the values from before this edge, independent of statement order.
    if (reset) begin
      state_q    <= S_REQ;
      pc_q       <= RESET_PC;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_q == instr_pc_d ? instr_pc_q : instr_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Handshake valids are decoded from the state register; they are masked by
  // reset so that nothing is offered during the reset cycle, whatever state
  // the register held before it.
  assign imem_req_valid = (state_q == S_REQ)  && !reset;
  assign instr_valid    = (state_q == S_HOLD) && !reset;

  assign imem_req_addr  = pc_q;
  assign instr          = instr_q;
  assign instr_pc       = instr_pc_q;
  assign instr_pc_plus4 = instr_pc_q + PC_STEP;

  // ---------------------------------------------------------------------------
  // Protocol checks (simulation only; ignored by synthesis)
  // ---------------------------------------------------------------------------
  // A response can only legally arrive while a request is outstanding.
  rsp_only_when_outstanding: assert property (
    @(posedge clk) disable iff (reset)
      !(imem_rsp_valid && (state_q == S_REQ || state_q == S_HOLD))
  );

  // A stalled request keeps its address unless it is redirected away.
  req_addr_stable: assert property (
    @(posedge clk) disable iff (reset)
      (imem_req_valid && !imem_req_ready && !pc_src)
        |=> (imem_req_valid && $stable(imem_req_addr))
  );

  // A stalled instruction stays put unless it is squashed by a redirect.
  instr_stable: assert property (
    @(posedge clk) disable iff (reset)
      (instr_valid && !instr_ready && !pc_src)
        |=> (instr_valid && $stable(instr) && $stable(instr_pc))
  );

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A small memory responder answers each
// accepted request with addr ^ 32'hA5A5_0000 after a programmable delay
// (0 = the cycle after acceptance). The main thread advances on falling
// edges, checks DUT outputs there and sets inputs for the next rising edge.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

  localparam logic [31:0] MASK = 32'hA5A5_0000;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        clk;
  logic        reset;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  int n_checks;
  int n_fail;

  // memory responder state
  int          mem_delay;
  int          mem_cnt;
  logic        mem_busy;
  logic [31:0] mem_addr;
  int          accept_count;

  fetch_unit dut (
    .clk            (clk),
    .reset          (reset),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory responder: runs just after each falling edge, once the main thread
  // has set imem_req_ready for the coming rising edge.
  initial begin
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    mem_busy       = 1'b0;
    mem_cnt        = 0;
    mem_addr       = '0;
    accept_count   = 0;
    forever begin
      @(negedge clk);
      #1;
      imem_rsp_valid = 1'b0;
      if (mem_busy) begin
        if (mem_cnt == 0) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_addr ^ MASK;
          mem_busy       = 1'b0;
        end else begin
          mem_cnt = mem_cnt - 1;
        end
      end
      if (reset) begin
        mem_busy = 1'b0;
      end else if (imem_req_valid && imem_req_ready) begin
        mem_busy     = 1'b1;
        mem_addr     = imem_req_addr;
        mem_cnt      = mem_delay;
        accept_count = accept_count + 1;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  task automatic cyc();
    @(negedge clk);
  endtask

  // Leaves the DUT in REQ with pc = 0, reset released for the next edge.
  task automatic apply_reset();
    reset          = 1'b1;
    pc_src         = 1'b0;
    pc_target      = '0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    mem_delay      = 0;
    cyc();
    cyc();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset          = 1'b1;
    pc_src         = 1'b0;
    pc_target      = '0;
    imem_req_ready = 1'b0;
    instr_ready    = 1'b0;
    mem_delay      = 0;
    cyc();
    n_checks++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset.req_valid got=%0b exp=0", imem_req_valid);
    end
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset.instr_valid got=%0b exp=0", instr_valid);
    end
    n_checks++;
    if (instr !== NOP) begin
      n_fail++; $display("FAIL reset.instr got=%h exp=%h", instr, NOP);
    end
    n_checks++;
    if (instr_pc !== 32'h0 || instr_pc_plus4 !== 32'h4) begin
      n_fail++; $display("FAIL reset.instr_pc got=%h/%h exp=0/4", instr_pc, instr_pc_plus4);
    end
    reset = 1'b0;
    cyc();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL reset.first_req got=%0b/%h exp=1/0", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    apply_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      n_checks++;
      if (instr_valid !== 1'((k % 3) == 2)) begin
        n_fail++; $display("FAIL stream.instr_valid k=%0d got=%0b exp=%0b", k, instr_valid, (k % 3) == 2);
      end
      n_checks++;
      if (imem_req_valid !== 1'((k % 3) == 0)) begin
        n_fail++; $display("FAIL stream.req_valid k=%0d got=%0b exp=%0b", k, imem_req_valid, (k % 3) == 0);
      end
      if ((k % 3) == 2) begin
        exp_pc = 32'((k / 3) * 4);
        n_checks++;
        if (instr_pc !== exp_pc || instr !== (exp_pc ^ MASK)
            || instr_pc_plus4 !== exp_pc + 32'd4) begin
          n_fail++; $display("FAIL stream.instr k=%0d got pc=%h instr=%h p4=%h exp pc=%h instr=%h",
                             k, instr_pc, instr, instr_pc_plus4, exp_pc, exp_pc ^ MASK);
        end
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      cyc();
      if (k == 6) instr_ready = 1'b0;
    end
    for (int j = 1; j <= 5; j++) begin
      cyc();
      n_checks++;
      if (instr_valid !== 1'b1 || instr_pc !== 32'h8 || instr !== (32'h8 ^ MASK)) begin
        n_fail++; $display("FAIL stall.hold j=%0d got v=%0b pc=%h instr=%h exp v=1 pc=8 instr=%h",
                           j, instr_valid, instr_pc, instr, 32'h8 ^ MASK);
      end
      n_checks++;
      if (imem_req_valid !== 1'b0) begin
        n_fail++; $display("FAIL stall.req_valid j=%0d got=%0b exp=0", j, imem_req_valid);
      end
    end
    instr_ready = 1'b1;
    cyc();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hC) begin
      n_fail++; $display("FAIL stall.next_req got=%0b/%h exp=1/c", imem_req_valid, imem_req_addr);
    end
    cyc();
    cyc();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hC || instr !== (32'hC ^ MASK)) begin
      n_fail++; $display("FAIL stall.next_instr got v=%0b pc=%h instr=%h exp v=1 pc=c", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_req_stall();
    int base;
    apply_reset();
    base        = accept_count;
    instr_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      n_checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
        n_fail++; $display("FAIL req_stall.hold k=%0d got=%0b/%h exp=1/0", k, imem_req_valid, imem_req_addr);
      end
    end
    imem_req_ready = 1'b1;
    cyc();
    imem_req_ready = 1'b0;
    n_checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL req_stall.wait got req=%0b iv=%0b exp 0/0", imem_req_valid, instr_valid);
    end
    cyc();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== MASK) begin
      n_fail++; $display("FAIL req_stall.instr got v=%0b pc=%h instr=%h exp v=1 pc=0 instr=%h", instr_valid, instr_pc, instr, MASK);
    end
    cyc();
    n_checks++;
    if (accept_count - base !== 1) begin
      n_fail++; $display("FAIL req_stall.accepts got=%0d exp=1", accept_count - base);
    end
  endtask

  task automatic test_redirect_wait();
    apply_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    mem_delay      = 2;
    cyc();                                  // WAIT for address 0
    pc_src    = 1'b1;
    pc_target = 32'h0000_0103;
    cyc();                                  // DRAIN
    pc_src    = 1'b0;
    mem_delay = 0;
    for (int k = 2; k <= 3; k++) begin
      n_checks++;
      if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP) begin
        n_fail++; $display("FAIL redir_wait.drain k=%0d got req=%0b iv=%0b instr=%h exp 0/0/%h",
                           k, imem_req_valid, instr_valid, instr, NOP);
      end
      cyc();
    end
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100 || instr_valid !== 1'b0 || instr !== NOP) begin
      n_fail++; $display("FAIL redir_wait.req got req=%0b addr=%h iv=%0b instr=%h exp 1/100/0/%h",
                         imem_req_valid, imem_req_addr, instr_valid, instr, NOP);
    end
    cyc();
    n_checks++;
    if (instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL redir_wait.wait_iv got=%0b exp=0", instr_valid);
    end
    cyc();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h100 || instr !== (32'h100 ^ MASK)) begin
      n_fail++; $display("FAIL redir_wait.instr got v=%0b pc=%h instr=%h exp v=1 pc=100 instr=%h",
                         instr_valid, instr_pc, instr, 32'h100 ^ MASK);
    end
  endtask

  task automatic test_redirect_hold();
    apply_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    for (int k = 1; k <= 8; k++) cyc();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h8) begin
      n_fail++; $display("FAIL redir_hold.pre got v=%0b pc=%h exp v=1 pc=8", instr_valid, instr_pc);
    end
    pc_src    = 1'b1;
    pc_target = 32'h0000_0040;
    cyc();
    pc_src = 1'b0;
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h40 || instr_valid !== 1'b0 || instr !== NOP) begin
      n_fail++; $display("FAIL redir_hold.req got req=%0b addr=%h iv=%0b instr=%h exp 1/40/0/%h",
                         imem_req_valid, imem_req_addr, instr_valid, instr, NOP);
    end
    cyc();
    cyc();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h40 || instr !== (32'h40 ^ MASK)) begin
      n_fail++; $display("FAIL redir_hold.instr got v=%0b pc=%h instr=%h exp v=1 pc=40", instr_valid, instr_pc, instr);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    pc_src         = 1'b1;               // redirect while request is accepted
    pc_target      = 32'hFFFF_FFFF;
    cyc();                               // DRAIN
    pc_src = 1'b0;
    n_checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL wrap.drain got req=%0b iv=%0b exp 0/0", imem_req_valid, instr_valid);
    end
    cyc();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      n_fail++; $display("FAIL wrap.req got=%0b/%h exp=1/fffffffc", imem_req_valid, imem_req_addr);
    end
    cyc();
    cyc();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'hFFFF_FFFC || instr !== 32'h5A5A_FFFC
        || instr_pc_plus4 !== 32'h0) begin
      n_fail++; $display("FAIL wrap.instr got v=%0b pc=%h instr=%h p4=%h exp v=1 pc=fffffffc instr=5a5afffc p4=0",
                         instr_valid, instr_pc, instr, instr_pc_plus4);
    end
    cyc();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++; $display("FAIL wrap.next_req got=%0b/%h exp=1/0", imem_req_valid, imem_req_addr);
    end
    cyc();
    cyc();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr_pc_plus4 !== 32'h4) begin
      n_fail++; $display("FAIL wrap.next_instr got v=%0b pc=%h p4=%h exp v=1 pc=0 p4=4", instr_valid, instr_pc, instr_pc_plus4);
    end
  endtask

  task automatic test_reset_wait();
    apply_reset();
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    mem_delay      = 1;
    cyc();                               // WAIT
    cyc();                               // still WAIT, response due next edge
    n_checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin
      n_fail++; $display("FAIL reset_wait.pre got req=%0b iv=%0b exp 0/0", imem_req_valid, instr_valid);
    end
    reset = 1'b1;                        // stale response lands in this cycle
    cyc();
    n_checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0 || instr !== NOP || instr_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_wait.in_reset got req=%0b iv=%0b instr=%h pc=%h exp 0/0/%h/0",
                         imem_req_valid, instr_valid, instr, instr_pc, NOP);
    end
    reset          = 1'b0;
    imem_req_ready = 1'b0;
    mem_delay      = 0;
    cyc();
    n_checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0 || instr_valid !== 1'b0 || instr !== NOP) begin
      n_fail++; $display("FAIL reset_wait.restart got req=%0b addr=%h iv=%0b instr=%h exp 1/0/0/%h",
                         imem_req_valid, imem_req_addr, instr_valid, instr, NOP);
    end
    imem_req_ready = 1'b1;
    cyc();
    cyc();
    n_checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0 || instr !== MASK) begin
      n_fail++; $display("FAIL reset_wait.instr got v=%0b pc=%h instr=%h exp v=1 pc=0 instr=%h", instr_valid, instr_pc, instr, MASK);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_stream();
    test_stall();
    test_req_stall();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_reset_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
